image_ram_streamer: RTL and testbench

- Downstream of Image_Generator: once a frame has been written to the image RAM, this block reads it back in raster order.
- Emits one pixel per transfer on a valid/ready stream toward the output/transport stage.
- Owns the RAM read port and hides the 1-cycle synchronous read latency behind a 2-entry output buffer, so full throughput is sustained under arbitrary backpressure.

---
 rtl/image_ram_streamer.sv | 224 ++++++++++++++++++++++
 tb/tb_image_ram_streamer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_ram_streamer.sv
// Reads a finished frame from the image RAM in raster order and streams it out one pixel per transfer.
// Optional running pixel checksum output is enabled by defining IMAGE_STREAMER_CHECKSUM_EN.
module image_ram_streamer #(
  parameter int unsigned IMAGE_WIDTH             = 320,
  parameter int unsigned IMAGE_HEIGHT            = 240,
  parameter int unsigned PIXEL_WIDTH             = 8,
  parameter int unsigned IMAGE_RAM_ADDRESS_WIDTH = 17
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  output logic                               busy,
  output logic                               done,
  output logic [IMAGE_RAM_ADDRESS_WIDTH-1:0] image_RAM_address,
  output logic                               image_RAM_RE,
  input  logic [PIXEL_WIDTH-1:0]             image_RAM_data,
  output logic [PIXEL_WIDTH-1:0]             pixel_data,
  output logic                               pixel_valid,
  input  logic                               pixel_ready,
  output logic                               pixel_eol,
  output logic                               pixel_eof
`ifdef IMAGE_STREAMER_CHECKSUM_EN
  ,
  output logic [15:0]                        frame_checksum
`endif
);

  localparam int unsigned AW = IMAGE_RAM_ADDRESS_WIDTH;
  localparam int unsigned PW = PIXEL_WIDTH;
  localparam int unsigned XW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int unsigned YW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(IMAGE_WIDTH * IMAGE_HEIGHT - 1);
  localparam logic [XW-1:0] LAST_X    = XW'(IMAGE_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;

  logic [XW-1:0]   x_q;
  logic [YW-1:0]   y_q;
  logic [AW-1:0]   addr_q;

  logic            inflight_q;
  logic            inflight_eol_q;
  logic            inflight_eof_q;

  logic [1:0]      cnt_q;
  logic [PW-1:0]   head_data_q, tail_data_q;
  logic            head_eol_q, tail_eol_q;
  logic            head_eof_q, tail_eof_q;
  logic            done_q;

  logic            pop_c;
  logic            room_c;
  logic            last_c;
  logic            issue_c;
  logic            accept_c;
  logic            final_xfer_c;
  logic [1:0]      occ_c;

  assign pop_c  = (cnt_q != 2'd0) && pixel_ready;
  assign last_c = (addr_q == LAST_ADDR);

  // Slots committed after this cycle's pop; a new read needs one free slot.
  assign occ_c  = cnt_q + 2'(inflight_q) - 2'(pop_c);
  assign room_c = (occ_c <= 2'd1);

  // Next-state and read-issue decision.
  always_comb begin
    state_d      = state_q;
    issue_c      = 1'b0;
    accept_c     = 1'b0;
    final_xfer_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !done_q) begin
          accept_c = 1'b1;
          issue_c  = 1'b1;
          state_d  = last_c ? S_DRAIN : S_READ;
        end
      end
      S_READ: begin
        if (room_c) begin
          issue_c = 1'b1;
          if (last_c) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (pop_c && head_eof_q) begin
          final_xfer_c = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= final_xfer_c;
    end
  end

  // Raster counters; the linear address is a plain incrementer that returns to 0 after the last read.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q    <= '0;
      y_q    <= '0;
      addr_q <= '0;
    end else if (issue_c) begin
      if (last_c) begin
        x_q    <= '0;
        y_q    <= '0;
        addr_q <= '0;
      end else begin
        addr_q <= addr_q + AW'(1);
        if (x_q == LAST_X) begin
          x_q <= '0;
          y_q <= y_q + YW'(1);
        end else begin
          x_q <= x_q + XW'(1);
        end
      end
    end
  end

  // Tags travel with the read so they line up with the returned data.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q     <= 1'b0;
      inflight_eol_q <= 1'b0;
      inflight_eof_q <= 1'b0;
    end else begin
      inflight_q     <= issue_c;
      inflight_eol_q <= issue_c && (x_q == LAST_X);
      inflight_eof_q <= issue_c && last_c;
    end
  end

  // Two-entry output buffer; the head entry drives the stream.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= 2'd0;
      head_data_q <= '0;
      head_eol_q  <= 1'b0;
      head_eof_q  <= 1'b0;
      tail_data_q <= '0;
      tail_eol_q  <= 1'b0;
      tail_eof_q  <= 1'b0;
    end else begin
      case ({inflight_q, pop_c})
        2'b10: begin
          if (cnt_q == 2'd0) begin
            head_data_q <= image_RAM_data;
            head_eol_q  <= inflight_eol_q;
            head_eof_q  <= inflight_eof_q;
          end else begin
            tail_data_q <= image_RAM_data;
            tail_eol_q  <= inflight_eol_q;
            tail_eof_q  <= inflight_eof_q;
          end
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          head_data_q <= tail_data_q;
          head_eol_q  <= tail_eol_q;
          head_eof_q  <= tail_eof_q;
          cnt_q       <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            head_data_q <= image_RAM_data;
            head_eol_q  <= inflight_eol_q;
            head_eof_q  <= inflight_eof_q;
          end else begin
            head_data_q <= tail_data_q;
            head_eol_q  <= tail_eol_q;
            head_eof_q  <= tail_eof_q;
            tail_data_q <= image_RAM_data;
            tail_eol_q  <= inflight_eol_q;
            tail_eof_q  <= inflight_eof_q;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef IMAGE_STREAMER_CHECKSUM_EN
  logic [15:0] checksum_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      checksum_q <= 16'd0;
    end else if (accept_c) begin
      checksum_q <= 16'd0;
    end else if (pop_c) begin
      checksum_q <= checksum_q + 16'(head_data_q);
    end
  end

  assign frame_checksum = checksum_q;
`endif

  assign busy              = (state_q != S_IDLE);
  assign done              = done_q;
  assign image_RAM_address = addr_q;
  assign image_RAM_RE      = issue_c && !rst;
  assign pixel_valid       = (cnt_q != 2'd0);
  assign pixel_data        = head_data_q;
  assign pixel_eol         = pixel_valid && head_eol_q;
  assign pixel_eof         = pixel_valid && head_eof_q;

endmodule

// File: tb/tb_image_ram_streamer.sv
// Scoreboard bench for image_ram_streamer on an 8x4 frame with a 1-cycle-latency RAM model (data = address[7:0]).
module tb_image_ram_streamer;

  localparam int unsigned W    = 8;
  localparam int unsigned H    = 4;
  localparam int unsigned PW   = 8;
  localparam int unsigned AW   = 17;
  localparam int unsigned NPIX = W * H;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy;
  logic          done;
  logic [AW-1:0] image_RAM_address;
  logic          image_RAM_RE;
  logic [PW-1:0] image_RAM_data;
  logic [PW-1:0] pixel_data;
  logic          pixel_valid;
  logic          pixel_ready;
  logic          pixel_eol;
  logic          pixel_eof;
`ifdef IMAGE_STREAMER_CHECKSUM_EN
  logic [15:0]   frame_checksum;
`endif

  image_ram_streamer #(
    .IMAGE_WIDTH(W),
    .IMAGE_HEIGHT(H),
    .PIXEL_WIDTH(PW),
    .IMAGE_RAM_ADDRESS_WIDTH(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .busy(busy),
    .done(done),
    .image_RAM_address(image_RAM_address),
    .image_RAM_RE(image_RAM_RE),
    .image_RAM_data(image_RAM_data),
    .pixel_data(pixel_data),
    .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready),
    .pixel_eol(pixel_eol),
    .pixel_eof(pixel_eof)
`ifdef IMAGE_STREAMER_CHECKSUM_EN
    ,
    .frame_checksum(frame_checksum)
`endif
  );

  always #5 clk = ~clk;

  // RAM model: registered read, data is the low address byte.
  logic [7:0] ram_q = 8'd0;
  always @(posedge clk) if (image_RAM_RE) ram_q <= image_RAM_address[7:0];
  assign image_RAM_data = ram_q;

  typedef struct packed {
    logic [7:0] data;
    logic       eol;
    logic       eof;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          ready_mode = 0;
  int          issued = 0;
  int          xfers = 0;
  int          done_cnt = 0;
  int          first_x = 0;
  int          last_x = 0;
  logic [15:0] exp_sum = 16'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Ready patterns: 0 always, 1 = 1,0,0,1 repeating, 2 random, 3 held low.
  int pat = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1:       pixel_ready = ((pat % 4) == 0) || ((pat % 4) == 3);
      2:       pixel_ready = 1'($urandom_range(0, 1));
      3:       pixel_ready = 1'b0;
      default: pixel_ready = 1'b1;
    endcase
    pat++;
  end

  // Monitor: scoreboard pops, hold-during-stall, read ordering, occupancy bound, done timing.
  exp_t       e;
  logic       xfer;
  logic       prev_stall = 1'b0;
  logic       prev_eofx = 1'b0;
  logic [9:0] prev_bus = '0;
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_stall = 1'b0;
      prev_eofx  = 1'b0;
      issued     = 0;
      xfers      = 0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 32'(pixel_valid), 32'd1);
        chk("hold_payload", 32'({pixel_data, pixel_eol, pixel_eof}), 32'(prev_bus));
      end
      if (done || prev_eofx) chk("done_timing", 32'(done), 32'(prev_eofx));
      xfer = pixel_valid && pixel_ready;
      if (image_RAM_RE) begin
        chk("rd_addr", 32'(image_RAM_address), 32'(issued));
        issued++;
      end
      if (xfer) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_xfer: got data 0x%0h, expected no transfer", pixel_data);
        end else begin
          e = sb.pop_front();
          chk("pixel", 32'({pixel_data, pixel_eol, pixel_eof}), 32'(e));
        end
        if (xfers == 0) first_x = cyc;
        last_x = cyc;
        xfers++;
      end
      if (image_RAM_RE) chk("outstanding_le2", 32'((issued - xfers) <= 2), 32'd1);
      prev_eofx  = xfer && pixel_eof;
      prev_stall = pixel_valid && !pixel_ready;
      prev_bus   = {pixel_data, pixel_eol, pixel_eof};
      if (done) begin
        done_cnt++;
        issued = 0;
        xfers  = 0;
      end
    end
  end

  task automatic start_frame(input bit check_lat);
    exp_t x;
    @(posedge clk);
    #1 start = 1'b1;
    exp_sum = 16'd0;
    for (int i = 0; i < int'(NPIX); i++) begin
      x.data = 8'(i % 256);
      x.eol  = ((i % int'(W)) == int'(W) - 1);
      x.eof  = (i == int'(NPIX) - 1);
      sb.push_back(x);
      exp_sum = exp_sum + 16'(i % 256);
    end
    @(negedge clk);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    if (check_lat) begin
      chk("busy_cycle1", 32'(busy), 32'd1);
      chk("valid_cycle1", 32'(pixel_valid), 32'd0);
    end
    @(negedge clk);
    if (check_lat) chk("valid_cycle2", 32'(pixel_valid), 32'd1);
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    tests++;
    if (done_cnt == d0) begin
      fails++;
      $display("FAIL done_timeout: got no done in %0d cycles, expected a done pulse", budget);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_re"}, 32'(image_RAM_RE), 32'd0);
    chk({tag, "_addr"}, 32'(image_RAM_address), 32'd0);
    chk({tag, "_valid"}, 32'(pixel_valid), 32'd0);
    chk({tag, "_payload"}, 32'({pixel_data, pixel_eol, pixel_eof}), 32'd0);
  endtask

  initial begin
    int n;
    int d0;
    rst = 1'b1;
    start = 1'b0;
    pixel_ready = 1'b1;

    // Reset and idle
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    check_reset_outputs("idle");
    chk("idle_no_done", 32'(done_cnt), 32'd0);
`ifdef IMAGE_STREAMER_CHECKSUM_EN
    chk("cks_reset", 32'(frame_checksum), 32'd0);
`endif

    // Full rate
    ready_mode = 0;
    start_frame(1'b1);
    wait_done(200);
    chk("full_rate_span", 32'(last_x - first_x), 32'(NPIX - 1));
    chk("full_rate_sb_empty", 32'(sb.size()), 32'd0);
    @(negedge clk);
    chk("busy_after_done", 32'(busy), 32'd0);
`ifdef IMAGE_STREAMER_CHECKSUM_EN
    chk("cks_full", 32'(frame_checksum), 32'(exp_sum));
    chk("cks_full_496", 32'(exp_sum), 32'd496);
`endif

    // Backpressure 1,0,0,1
    ready_mode = 1;
    start_frame(1'b1);
    wait_done(400);
    chk("bp_sb_empty", 32'(sb.size()), 32'd0);

    // Random ready with an ignored start mid-frame
    ready_mode = 2;
    start_frame(1'b1);
    repeat (5) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(600);
    chk("rand_sb_empty", 32'(sb.size()), 32'd0);
`ifdef IMAGE_STREAMER_CHECKSUM_EN
    repeat (3) @(negedge clk);
    chk("cks_hold", 32'(frame_checksum), 32'(exp_sum));
`endif

    // Long stall: two pixels buffered, no further reads
    ready_mode = 3;
    start_frame(1'b1);
    repeat (20) @(negedge clk);
    chk("stall_re", 32'(image_RAM_RE), 32'd0);
    chk("stall_valid", 32'(pixel_valid), 32'd1);
    chk("stall_issued", 32'(issued), 32'd2);
    ready_mode = 0;
    wait_done(200);
    chk("stall_sb_empty", 32'(sb.size()), 32'd0);

    // Reset mid-frame, then restart
    ready_mode = 0;
    d0 = done_cnt;
    start_frame(1'b0);
    n = 0;
    while (xfers < 10 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    repeat (5) @(negedge clk);
    chk("midrst_no_done", 32'(done_cnt), 32'(d0));
    start_frame(1'b1);
    wait_done(200);
    chk("restart_sb_empty", 32'(sb.size()), 32'd0);

    // start in the done cycle is ignored
    ready_mode = 2;
    start_frame(1'b0);
    n = 0;
    while (!(pixel_valid && pixel_ready && pixel_eof) && n < 600) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 start = 1'b1;
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd1);
    chk("re_in_done_cycle", 32'(image_RAM_RE), 32'd0);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("busy_after_ignored_start", 32'(busy), 32'd0);
    repeat (10) @(negedge clk);
    chk("ignored_start_no_valid", 32'(pixel_valid), 32'd0);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish by time %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
